// File: rtl/serial_tx.sv
// 8N1 UART transmitter with a one-byte holding register in front of the shifter.
// Bit timing comes from a clk-cycle divider; the serial line is driven from a register.
module serial_tx #(
  parameter int HIGH_CLK = 50_000_000,
  parameter int BAUD_CLK = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] txdata_in,
  input  logic       txdata_valid_in,
  output logic       txdata_ready_out,
  output logic       txdata_out,
  output logic       txdata_busy_out,
  output logic       txdata_done_out
);

  localparam int DIV = HIGH_CLK / BAUD_CLK;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] bitcnt, bitcnt_n;
  logic [2:0]    bitidx, bitidx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    hold, hold_n;
  logic          hold_full, hold_full_n;
  logic          line_n;
  logic          load;
  logic          end_bit;

  assign end_bit          = (bitcnt == LAST);
  assign txdata_ready_out = !hold_full;
  assign txdata_busy_out  = (state != IDLE);
  assign txdata_done_out  = (state == STOP) && end_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      bitidx     <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      txdata_out <= 1'b1;
    end else begin
      state      <= state_n;
      bitcnt     <= bitcnt_n;
      bitidx     <= bitidx_n;
      shift      <= shift_n;
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      txdata_out <= line_n;
    end
  end

  always_comb begin
    state_n     = state;
    bitcnt_n    = bitcnt;
    bitidx_n    = bitidx;
    shift_n     = shift;
    hold_n      = hold;
    hold_full_n = hold_full;
    line_n      = 1'b1;
    load        = 1'b0;

    if (state != IDLE) begin
      bitcnt_n = end_bit ? '0 : bitcnt + 1'b1;
    end

    case (state)
      IDLE: load = hold_full && enable;
      START: begin
        if (end_bit) begin
          state_n  = DATA;
          bitidx_n = '0;
        end
      end
      DATA: begin
        if (end_bit) begin
          shift_n = {1'b0, shift[7:1]};
          if (bitidx == 3'd7) state_n = STOP;
          else bitidx_n = bitidx + 3'd1;
        end
      end
      STOP: begin
        if (end_bit) begin
          if (hold_full && enable) load = 1'b1;
          else state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Loading the shifter frees the holding register; an accept can only happen while it is empty
    if (load) begin
      state_n     = START;
      shift_n     = hold;
      hold_full_n = 1'b0;
      bitcnt_n    = '0;
    end

    if (txdata_valid_in && !hold_full) begin
      hold_n      = txdata_in;
      hold_full_n = 1'b1;
    end

    // Line value follows the state being entered so the output register carries it glitch-free
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
      default: line_n = 1'b1;
    endcase
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

UART transmitter paired with `serial_rx` on the host link of the Connect-6 engine. It takes bytes through a valid/ready handshake and buffers one byte in a holding register while another byte is being shifted. It serialises each byte as 8N1, LSB first, on a single line that idles high. Bit timing comes from an internal divider running on the system clock; no derived clocks are used.

## Interface
- `HIGH_CLK`, default 50_000_000: system clock frequency in Hz.
- `BAUD_CLK`, default 115_200: line rate in baud.
- Derived `DIV = HIGH_CLK / BAUD_CLK` (integer division; 434 at defaults). This is the bit period in clk cycles. `DIV >= 2` is required.

- `clk` in 1: system clock. One clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when high, a new frame may start. It does not stall a frame already in progress.
- `txdata_in` in 8: byte to send.
- `txdata_valid_in` in 1: `txdata_in` is valid.
- `txdata_ready_out` out 1: the holding register is empty and can take a byte.
- `txdata_out` out 1: serial line, registered.
- `txdata_busy_out` out 1: FSM is not in IDLE.
- `txdata_done_out` out 1: one-cycle pulse at the end of each stop bit.

## Operation
- Handshake: a byte is accepted on an edge where `txdata_valid_in && txdata_ready_out`. It goes into the holding register and sets `hold_full`. `txdata_ready_out = !hold_full`, decoded from registered state.
- FSM states:
  - IDLE: line is 1.
  - START: line is 0.
  - DATA: line is `shift[0]`. Bit index 0..7.
  - STOP: line is 1.
- Bit counter: `bitcnt` counts 0..DIV-1. A bit ends when `bitcnt == DIV-1`; the counter then returns to 0.
- IDLE -> START when `hold_full && enable`:
  - holding register is copied to `shift`;
  - `hold_full` clears;
  - `bitcnt` is set to 0.
- START -> DATA at end of bit, with bit index 0.
- DATA: at end of each bit, `shift` shifts right by one. After bit 7 the FSM goes to STOP.
- At the end of STOP, `txdata_done_out` pulses. Then:
  - if `hold_full && enable`: go directly to START and load the next byte (no idle gap);
  - otherwise: go to IDLE.
- `enable` low:
  - blocks only the IDLE/STOP -> START transitions;
  - the handshake still accepts one byte into the holding register;
  - that byte waits until `enable` is high.
- `txdata_out` is a registered function of state: START gives 0, DATA gives `shift[0]`, IDLE and STOP give 1. It never glitches.
- Reset, including mid-frame, on the next edge:
  - FSM goes to IDLE;
  - `hold_full` = 0 and `bitcnt` = 0;
  - the frame in progress and the held byte are dropped, and no done pulse is issued.
- Reset values: `txdata_out`=1, `txdata_ready_out`=1, `txdata_busy_out`=0, `txdata_done_out`=0.

## Timing
- Let the handshake edge be E, with the FSM in IDLE and `enable` high.
  - `hold_full` is 1 after E, so `txdata_ready_out` = 0 for one cycle.
  - At E+1: FSM enters START, `txdata_out` = 0, and `txdata_ready_out` returns to 1.
- Bit k of the frame (k=0 is start, 1..8 are data LSB-first, 9 is stop) is driven from edge E+1+k·DIV for exactly DIV cycles.
- `txdata_done_out` is high for the single cycle after edge E+10·DIV.
- Next state follows edge E+1+10·DIV:
  - with a byte held: the next start bit begins there;
  - otherwise: the FSM is in IDLE and `txdata_busy_out` = 0.
- Sustained throughput is 1 byte per 10·DIV cycles when the source keeps the holding register full.
- While `hold_full` = 1, `txdata_valid_in` is ignored and the data is not sampled. The source must hold its byte until ready.

## Test plan
- Single byte: HIGH_CLK=16, BAUD_CLK=1 (DIV=16). Send 0x55 at edge E.
  - Line is 0 for cycles E+1..E+16.
  - Data bits follow as 1,0,1,0,1,0,1,0, 16 cycles each.
  - Stop is 1 for 16 cycles, with `done` pulsing once.
  - A `serial_rx` model decodes 0x55.
- Back-to-back: send 0xA3 and, while it is shifting, 0x0F.
  - The 0x0F start bit follows the 0xA3 stop with zero idle cycles.
  - Ready is low from accept of 0x0F until its load.
  - A third valid is held off until then.
- Backpressure: keep valid high with 3 distinct bytes queued by the source.
  - Exactly 3 frames go out, in order, with no byte duplicated or lost.
  - Every accepted byte matches the byte that was on `txdata_in` at its accept edge.
- Enable gating: enable=0, send 0xC6.
  - Ready drops, the line stays 1 for 100 cycles, and busy = 0.
  - Raising enable makes the start bit begin one edge later.
  - Dropping enable mid-frame does not truncate the frame.
- Reset mid-frame: assert reset during data bit 3 of 0xFF, with 0x11 held.
  - After the reset edge: line = 1, ready = 1, busy = 0, and done never pulses.
  - After reset releases, no frame is sent until a new handshake.
- Divider edge: DIV=2. Send 0x80; every bit lasts exactly 2 cycles and the frame length is 20 cycles.
